// File: rtl/minicpu_pkg.sv
// Shared types and opcode field constants for the multi-cycle miniCPU core.
package minicpu_pkg;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_LUI} alu_op_t;

  // add_w/sub_w match inst[31:15]; addi_w/ld_w/st_w match inst[31:22]
  localparam logic [16:0] OP_ADD_W   = 17'h00020;
  localparam logic [16:0] OP_SUB_W   = 17'h00022;
  localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
  localparam logic [9:0]  OP_LD_W    = 10'h0a2;
  localparam logic [9:0]  OP_ST_W    = 10'h0a6;
  // branches match inst[31:26]; lu12i_w matches inst[31:25]
  localparam logic [5:0]  OP_BEQ     = 6'h16;
  localparam logic [5:0]  OP_BNE     = 6'h17;
  localparam logic [5:0]  OP_B       = 6'h14;
  localparam logic [6:0]  OP_LU12I_W = 7'b0001010;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/minicpu_multicycle_regfile.sv
// 32x32 register file, two async read ports and one write port; r0 reads zero and ignores writes.
// Contents are not reset.
module minicpu_multicycle_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/minicpu_multicycle.sv
// Multi-cycle LoongArch-32 subset core: one FSM steps IF/ID/EX/MEM/WB, SRAM ports stall on req/ack.
// Define MINICPU_TRACE_EN to add the one-cycle-per-retire debug_wb_* trace outputs.
module minicpu_multicycle
  import minicpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             inst_sram_req,
  output logic [31:0]      inst_sram_addr,
  input  logic             inst_sram_ack,
  input  logic [31:0]      inst_sram_rdata,
  output logic             data_sram_req,
  output logic             data_sram_we,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_ack,
  input  logic [31:0]      data_sram_rdata,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`ifdef MINICPU_TRACE_EN
  ,
  output logic [31:0]      debug_wb_pc,
  output logic             debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
`endif
);

  state_t      state;
  logic [31:0] pc, ir, a_q, b_q, res_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        mem_we_q;

  logic [4:0]  rd, rj, rk;
  logic        op_add, op_sub, op_addi, op_ld, op_st, op_beq, op_bne, op_b, op_lui;
  logic        is_br, writes_rd, br_taken, retire, rf_we;
  logic [31:0] pc_plus4, br_off, br_target, opnd2, alu_out, rf_rdata1, rf_rdata2;
  alu_op_t     alu_op;

  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];

  assign op_add  = (ir[31:15] == OP_ADD_W);
  assign op_sub  = (ir[31:15] == OP_SUB_W);
  assign op_addi = (ir[31:22] == OP_ADDI_W);
  assign op_ld   = (ir[31:22] == OP_LD_W);
  assign op_st   = (ir[31:22] == OP_ST_W);
  assign op_beq  = (ir[31:26] == OP_BEQ);
  assign op_bne  = (ir[31:26] == OP_BNE);
  assign op_b    = (ir[31:26] == OP_B);
  assign op_lui  = (ir[31:25] == OP_LU12I_W);

  assign is_br     = op_beq | op_bne | op_b;
  assign writes_rd = op_add | op_sub | op_addi | op_ld | op_lui;
  assign br_taken  = op_b | (op_beq & (a_q == b_q)) | (op_bne & (a_q != b_q));
  // b carries offs26 split as {inst[9:0], inst[25:10]}
  assign br_off    = op_b ? {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00}
                          : {{14{ir[25]}}, ir[25:10], 2'b00};
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc + br_off;

  always_comb begin
    alu_op = ALU_ADD;
    opnd2  = sext12(ir[21:10]);
    if (op_add) begin
      opnd2 = b_q;
    end else if (op_sub) begin
      alu_op = ALU_SUB;
      opnd2  = b_q;
    end else if (op_lui) begin
      alu_op = ALU_LUI;
      opnd2  = {ir[24:5], 12'b0};
    end
    case (alu_op)
      ALU_SUB: alu_out = a_q - opnd2;
      ALU_LUI: alu_out = opnd2;
      default: alu_out = a_q + opnd2;
    endcase
  end

  assign rf_we  = (state == S_WB) && writes_rd;
  assign retire = ((state == S_EX) && is_br) ||
                  ((state == S_MEM) && data_sram_ack && op_st) ||
                  (state == S_WB);

  minicpu_multicycle_regfile u_rf (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rf_rdata1),
    .raddr2 ((op_add | op_sub) ? rk : rd),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (res_q)
  );

  // State resets to IF, so the fetch request is masked while reset is held.
  assign inst_sram_req   = (state == S_IF) && !reset;
  assign inst_sram_addr  = pc;
  assign data_sram_req   = (state == S_MEM);
  assign data_sram_we    = mem_we_q;
  assign data_sram_addr  = mem_addr_q;
  assign data_sram_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
      pc    <= RESET_PC;
    end else begin
      case (state)
        S_IF: begin
          if (inst_sram_ack) begin
            ir    <= inst_sram_rdata;
            state <= S_ID;
          end
        end
        S_ID: begin
          a_q   <= rf_rdata1;
          b_q   <= rf_rdata2;
          state <= S_EX;
        end
        S_EX: begin
          res_q       <= alu_out;
          mem_addr_q  <= alu_out;
          mem_wdata_q <= b_q;
          mem_we_q    <= op_st;
          if (is_br) begin
            pc    <= br_taken ? br_target : pc_plus4;
            state <= S_IF;
          end else if (op_ld || op_st) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (data_sram_ack) begin
            if (op_st) begin
              pc    <= pc_plus4;
              state <= S_IF;
            end else begin
              res_q <= data_sram_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc    <= pc_plus4;
          state <= S_IF;
        end
        default: state <= S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

`ifdef MINICPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset || !retire) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_pc       <= pc;
      debug_wb_rf_we    <= rf_we && (rd != 5'd0);
      debug_wb_rf_wnum  <= rf_we ? rd : 5'd0;
      debug_wb_rf_wdata <= rf_we ? res_q : 32'd0;
    end
  end
`endif

endmodule
